// File: rtl/ctrl_exec_pkg.sv
// Shared types and helpers for the control-execution cluster: branch kinds,
// per-lane output packets and CTI age arithmetic.
package ctrl_exec_pkg;

  localparam int unsigned PKT_PC_W   = 64;
  localparam int unsigned PKT_DATA_W = 64;
  localparam int unsigned PKT_AL_W   = 8;
  localparam int unsigned PKT_PHY_W  = 7;

  typedef enum logic [3:0] {
    BR_BEQ  = 4'd0,
    BR_BNE  = 4'd1,
    BR_BLT  = 4'd2,
    BR_BGE  = 4'd3,
    BR_BLTU = 4'd4,
    BR_BGEU = 4'd5,
    BR_JAL  = 4'd6,
    BR_JALR = 4'd7
  } brTypeEnum;

  typedef struct packed {
    logic [PKT_AL_W-1:0] alId;
    logic                mispred;
    logic [PKT_PC_W-1:0] npc;
  } ctrlLanePkt;

  typedef struct packed {
    logic [PKT_PHY_W-1:0]  tag;
    logic [PKT_DATA_W-1:0] data;
    logic                  valid;
  } ctrlBypassPkt;

  // Distance of a CTI from the ring head; smaller means older.
  function automatic int unsigned ctiAge(int unsigned ctiId, int unsigned ctiHead,
                                         int unsigned ctiLog);
    int unsigned mask;
    mask = (32'd1 << ctiLog) - 32'd1;
    return (ctiId - ctiHead) & mask;
  endfunction

endpackage

// File: rtl/ctrl_exec_lane.sv
// One branch-resolution lane: issue latch, combinational resolve and the
// registered control/bypass outputs. Kill decisions come from the cluster.
module ctrl_exec_lane
  import ctrl_exec_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned PC_W    = 64,
  parameter int unsigned CTI_LOG = 5,
  parameter int unsigned AL_LOG  = 8,
  parameter int unsigned PHY_LOG = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               laneActive,
  input  logic               issueValid,
  input  logic [PC_W-1:0]    pc,
  input  logic [PC_W-1:0]    predNPC,
  input  logic [3:0]         brType,
  input  logic [PC_W-1:0]    imm,
  input  logic [CTI_LOG-1:0] ctiId,
  input  logic [AL_LOG-1:0]  alId,
  input  logic [PHY_LOG-1:0] phyDest,
  input  logic               destValid,
  input  logic [DATA_W-1:0]  src1Data,
  input  logic [DATA_W-1:0]  src2Data,
  input  logic               kill,
  output logic               e1Valid_c,
  output logic               e1Mispred_c,
  output logic [CTI_LOG-1:0] e1CtiId_c,
  output logic [PC_W-1:0]    e1NPC_c,
  output logic               ctrlValid,
  output ctrlLanePkt         ctrlPkt,
  output ctrlBypassPkt       bypassPkt
);

  logic               e0Valid;
  logic [PC_W-1:0]    e0Pc;
  logic [PC_W-1:0]    e0PredNPC;
  logic [3:0]         e0BrType;
  logic [PC_W-1:0]    e0Imm;
  logic [CTI_LOG-1:0] e0CtiId;
  logic [AL_LOG-1:0]  e0AlId;
  logic [PHY_LOG-1:0] e0PhyDest;
  logic               e0DestValid;
  logic [DATA_W-1:0]  e0Src1;
  logic [DATA_W-1:0]  e0Src2;

  logic               issueTake;
  logic               outValid;
  logic               taken;
  logic [PC_W-1:0]    fallThrough;
  logic [PC_W-1:0]    brTarget;
  logic [PC_W-1:0]    jalrSum;
  logic [PC_W-1:0]    actualNPC;
  ctrlLanePkt         ctrlNext;
  ctrlBypassPkt       bypassNext;

  assign issueTake = issueValid & laneActive;
  assign outValid  = e0Valid & ~kill;

  // Resolve the latched packet: taken decision and actual next PC.
  always_comb begin
    fallThrough = e0Pc + PC_W'(4);
    brTarget    = e0Pc + e0Imm;
    jalrSum     = PC_W'(e0Src1) + e0Imm;
    taken       = 1'b0;
    case (e0BrType)
      BR_BEQ:  taken = (e0Src1 == e0Src2);
      BR_BNE:  taken = (e0Src1 != e0Src2);
      BR_BLT:  taken = ($signed(e0Src1) < $signed(e0Src2));
      BR_BGE:  taken = ($signed(e0Src1) >= $signed(e0Src2));
      BR_BLTU: taken = (e0Src1 < e0Src2);
      BR_BGEU: taken = (e0Src1 >= e0Src2);
      BR_JAL:  taken = 1'b1;
      BR_JALR: taken = 1'b1;
      default: taken = 1'b0;
    endcase
    actualNPC = fallThrough;
    if (taken) begin
      actualNPC = (e0BrType == BR_JALR) ? (jalrSum & ~PC_W'(1)) : brTarget;
    end
  end

  assign e1Valid_c   = e0Valid;
  assign e1Mispred_c = (actualNPC != e0PredNPC);
  assign e1CtiId_c   = e0CtiId;
  assign e1NPC_c     = actualNPC;

  // Killed or empty slots register as all-zero packets.
  always_comb begin
    ctrlNext   = '0;
    bypassNext = '0;
    if (outValid) begin
      ctrlNext.alId    = PKT_AL_W'(e0AlId);
      ctrlNext.mispred = e1Mispred_c;
      ctrlNext.npc     = PKT_PC_W'(actualNPC);
      if (e0DestValid) begin
        bypassNext.valid = 1'b1;
        bypassNext.tag   = PKT_PHY_W'(e0PhyDest);
        bypassNext.data  = PKT_DATA_W'(DATA_W'(fallThrough));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      e0Valid     <= 1'b0;
      e0Pc        <= '0;
      e0PredNPC   <= '0;
      e0BrType    <= '0;
      e0Imm       <= '0;
      e0CtiId     <= '0;
      e0AlId      <= '0;
      e0PhyDest   <= '0;
      e0DestValid <= 1'b0;
      e0Src1      <= '0;
      e0Src2      <= '0;
      ctrlValid   <= 1'b0;
      ctrlPkt     <= '0;
      bypassPkt   <= '0;
    end else begin
      e0Valid <= issueTake;
      if (issueTake) begin
        e0Pc        <= pc;
        e0PredNPC   <= predNPC;
        e0BrType    <= brType;
        e0Imm       <= imm;
        e0CtiId     <= ctiId;
        e0AlId      <= alId;
        e0PhyDest   <= phyDest;
        e0DestValid <= destValid;
        e0Src1      <= src1Data;
        e0Src2      <= src2Data;
      end
      ctrlValid <= outValid;
      ctrlPkt   <= ctrlNext;
      bypassPkt <= bypassNext;
    end
  end

endmodule

// File: rtl/ctrl_exec_cluster.sv
// Multi-lane control execution cluster: per-lane branch resolution, an age
// arbiter that picks the oldest mispredict, and a sticky wrong-path kill filter.
module ctrl_exec_cluster
  import ctrl_exec_pkg::*;
#(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned PC_W      = 64,
  parameter int unsigned CTI_LOG   = 5,
  parameter int unsigned AL_LOG    = 8,
  parameter int unsigned PHY_LOG   = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic [NUM_LANES-1:0] laneActive_i,
  input  logic [CTI_LOG-1:0]   ctiHead_i,
  input  logic                 issueValid_i    [NUM_LANES],
  input  logic [PC_W-1:0]      pc_i            [NUM_LANES],
  input  logic [PC_W-1:0]      predNPC_i       [NUM_LANES],
  input  logic [3:0]           brType_i        [NUM_LANES],
  input  logic [PC_W-1:0]      imm_i           [NUM_LANES],
  input  logic [CTI_LOG-1:0]   ctiId_i         [NUM_LANES],
  input  logic [AL_LOG-1:0]    alId_i          [NUM_LANES],
  input  logic [PHY_LOG-1:0]   phyDest_i       [NUM_LANES],
  input  logic                 destValid_i     [NUM_LANES],
  input  logic [DATA_W-1:0]    src1Data_i      [NUM_LANES],
  input  logic [DATA_W-1:0]    src2Data_i      [NUM_LANES],
  output logic                 bypassValid_o   [NUM_LANES],
  output logic [PHY_LOG-1:0]   bypassTag_o     [NUM_LANES],
  output logic [DATA_W-1:0]    bypassData_o    [NUM_LANES],
  output logic                 ctrlValid_o     [NUM_LANES],
  output logic [AL_LOG-1:0]    ctrlAlId_o      [NUM_LANES],
  output logic                 ctrlMispred_o   [NUM_LANES],
  output logic [PC_W-1:0]      ctrlNPC_o       [NUM_LANES],
  output logic                 redirectValid_o,
  output logic [PC_W-1:0]      redirectPC_o,
  output logic [CTI_LOG-1:0]   redirectCtiId_o
);

  logic [NUM_LANES-1:0] e1Valid_c;
  logic [NUM_LANES-1:0] e1Mispred_c;
  logic [NUM_LANES-1:0] laneKill_c;
  logic [CTI_LOG-1:0]   e1CtiId_c [NUM_LANES];
  logic [PC_W-1:0]      e1NPC_c   [NUM_LANES];
  logic [CTI_LOG-1:0]   laneAge_c [NUM_LANES];
  ctrlLanePkt           ctrlPkt   [NUM_LANES];
  ctrlBypassPkt         bypassPkt [NUM_LANES];

  logic                 killValid;
  logic [CTI_LOG-1:0]   killCti;
  logic [CTI_LOG-1:0]   killAge_c;
  logic                 winValid_c;
  logic [CTI_LOG-1:0]   winAge_c;
  logic [CTI_LOG-1:0]   winCti_c;
  logic [PC_W-1:0]      winNPC_c;

  for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
    ctrl_exec_lane #(
      .DATA_W (DATA_W),
      .PC_W   (PC_W),
      .CTI_LOG(CTI_LOG),
      .AL_LOG (AL_LOG),
      .PHY_LOG(PHY_LOG)
    ) uLane (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush_i),
      .laneActive (laneActive_i[i]),
      .issueValid (issueValid_i[i]),
      .pc         (pc_i[i]),
      .predNPC    (predNPC_i[i]),
      .brType     (brType_i[i]),
      .imm        (imm_i[i]),
      .ctiId      (ctiId_i[i]),
      .alId       (alId_i[i]),
      .phyDest    (phyDest_i[i]),
      .destValid  (destValid_i[i]),
      .src1Data   (src1Data_i[i]),
      .src2Data   (src2Data_i[i]),
      .kill       (laneKill_c[i]),
      .e1Valid_c  (e1Valid_c[i]),
      .e1Mispred_c(e1Mispred_c[i]),
      .e1CtiId_c  (e1CtiId_c[i]),
      .e1NPC_c    (e1NPC_c[i]),
      .ctrlValid  (ctrlValid_o[i]),
      .ctrlPkt    (ctrlPkt[i]),
      .bypassPkt  (bypassPkt[i])
    );

    assign ctrlAlId_o[i]    = AL_LOG'(ctrlPkt[i].alId);
    assign ctrlMispred_o[i] = ctrlPkt[i].mispred;
    assign ctrlNPC_o[i]     = PC_W'(ctrlPkt[i].npc);
    assign bypassValid_o[i] = bypassPkt[i].valid;
    assign bypassTag_o[i]   = PHY_LOG'(bypassPkt[i].tag);
    assign bypassData_o[i]  = DATA_W'(bypassPkt[i].data);
  end

  // Oldest surviving mispredict wins; anything younger than the kill point or
  // the winner is on the wrong path. Ties go to the lowest lane.
  always_comb begin
    laneAge_c  = '{default: '0};
    laneKill_c = '0;
    killAge_c  = CTI_LOG'(ctiAge(32'(killCti), 32'(ctiHead_i), CTI_LOG));
    winValid_c = 1'b0;
    winAge_c   = '0;
    winCti_c   = '0;
    winNPC_c   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      laneAge_c[i] = CTI_LOG'(ctiAge(32'(e1CtiId_c[i]), 32'(ctiHead_i), CTI_LOG));
      if (e1Valid_c[i] && e1Mispred_c[i] && !(killValid && (laneAge_c[i] > killAge_c)) &&
          (!winValid_c || (laneAge_c[i] < winAge_c))) begin
        winValid_c = 1'b1;
        winAge_c   = laneAge_c[i];
        winCti_c   = e1CtiId_c[i];
        winNPC_c   = e1NPC_c[i];
      end
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      laneKill_c[i] = (killValid && (laneAge_c[i] > killAge_c)) ||
                      (winValid_c && (laneAge_c[i] > winAge_c));
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      killValid       <= 1'b0;
      killCti         <= '0;
      redirectValid_o <= 1'b0;
      redirectPC_o    <= '0;
      redirectCtiId_o <= '0;
    end else begin
      redirectValid_o <= winValid_c;
      redirectPC_o    <= winNPC_c;
      redirectCtiId_o <= winCti_c;
      if (winValid_c) begin
        killValid <= 1'b1;
        killCti   <= winCti_c;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_exec_cluster.sv
// Scoreboard bench for ctrl_exec_cluster: directed cases plus random traffic
// checked cycle by cycle against a behavioural reference model.
module tb_ctrl_exec_cluster;
  import ctrl_exec_pkg::*;

  localparam int unsigned NL = 2;
  localparam int unsigned DW = 64;
  localparam int unsigned PW = 64;
  localparam int unsigned CL = 5;
  localparam int unsigned AL = 8;
  localparam int unsigned PL = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush_i = 1'b0;
  logic [NL-1:0] laneActive_i = '1;
  logic [CL-1:0] ctiHead_i = '0;
  logic          issueValid_i  [NL];
  logic [PW-1:0] pc_i          [NL];
  logic [PW-1:0] predNPC_i     [NL];
  logic [3:0]    brType_i      [NL];
  logic [PW-1:0] imm_i         [NL];
  logic [CL-1:0] ctiId_i       [NL];
  logic [AL-1:0] alId_i        [NL];
  logic [PL-1:0] phyDest_i     [NL];
  logic          destValid_i   [NL];
  logic [DW-1:0] src1Data_i    [NL];
  logic [DW-1:0] src2Data_i    [NL];
  logic          bypassValid_o [NL];
  logic [PL-1:0] bypassTag_o   [NL];
  logic [DW-1:0] bypassData_o  [NL];
  logic          ctrlValid_o   [NL];
  logic [AL-1:0] ctrlAlId_o    [NL];
  logic          ctrlMispred_o [NL];
  logic [PW-1:0] ctrlNPC_o     [NL];
  logic          redirectValid_o;
  logic [PW-1:0] redirectPC_o;
  logic [CL-1:0] redirectCtiId_o;

  ctrl_exec_cluster #(
    .NUM_LANES(NL), .DATA_W(DW), .PC_W(PW), .CTI_LOG(CL), .AL_LOG(AL), .PHY_LOG(PL)
  ) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .laneActive_i(laneActive_i),
    .ctiHead_i(ctiHead_i), .issueValid_i(issueValid_i), .pc_i(pc_i),
    .predNPC_i(predNPC_i), .brType_i(brType_i), .imm_i(imm_i), .ctiId_i(ctiId_i),
    .alId_i(alId_i), .phyDest_i(phyDest_i), .destValid_i(destValid_i),
    .src1Data_i(src1Data_i), .src2Data_i(src2Data_i),
    .bypassValid_o(bypassValid_o), .bypassTag_o(bypassTag_o), .bypassData_o(bypassData_o),
    .ctrlValid_o(ctrlValid_o), .ctrlAlId_o(ctrlAlId_o), .ctrlMispred_o(ctrlMispred_o),
    .ctrlNPC_o(ctrlNPC_o), .redirectValid_o(redirectValid_o), .redirectPC_o(redirectPC_o),
    .redirectCtiId_o(redirectCtiId_o)
  );

  always #5 clk = ~clk;

  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  typedef struct packed {
    logic [31:0]            cyc;
    logic [NL-1:0]          cv;
    logic [NL-1:0]          mp;
    logic [NL-1:0]          bv;
    logic [NL-1:0][AL-1:0]  al;
    logic [NL-1:0][PW-1:0]  npc;
    logic [NL-1:0][PL-1:0]  tag;
    logic [NL-1:0][DW-1:0]  data;
    logic                   rv;
    logic [PW-1:0]          rpc;
    logic [CL-1:0]          rcti;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int nChk = 0;
  int nFail = 0;
  int nRedir = 0;

  // Model state: packets waiting to resolve and the wrong-path marker.
  logic          pv   [NL];
  logic [63:0]   ppc  [NL];
  logic [63:0]   ppred[NL];
  logic [63:0]   pimm [NL];
  logic [63:0]   ps1  [NL];
  logic [63:0]   ps2  [NL];
  logic [3:0]    pty  [NL];
  logic [CL-1:0] pcti [NL];
  logic [AL-1:0] pal  [NL];
  logic [PL-1:0] ptag [NL];
  logic          pdv  [NL];
  logic          mKillV = 1'b0;
  logic [CL-1:0] mKillCti = '0;

  function automatic void chk(string nm, int ln, logic [63:0] act, logic [63:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s lane%0d cyc=%0d got=%h want=%h", nm, ln, cyc, act, exp);
    end
  endfunction

  function automatic int ageOf(logic [CL-1:0] id, logic [CL-1:0] h);
    return (int'(id) - int'(h) + (1 << CL)) % (1 << CL);
  endfunction

  function automatic logic [63:0] refNpc(logic [3:0] ty, logic [63:0] pc, logic [63:0] imm,
                                         logic [63:0] s1, logic [63:0] s2);
    logic [63:0] fall;
    logic [63:0] tgt;
    logic        tk;
    fall = pc + 64'd4;
    tgt  = pc + imm;
    case (ty)
      BR_BEQ:  tk = (s1 == s2);
      BR_BNE:  tk = (s1 != s2);
      BR_BLT:  tk = ($signed(s1) < $signed(s2));
      BR_BGE:  tk = !($signed(s1) < $signed(s2));
      BR_BLTU: tk = (s1 < s2);
      BR_BGEU: tk = !(s1 < s2);
      BR_JAL:  tk = 1'b1;
      BR_JALR: begin tk = 1'b1; tgt = (s1 + imm) & ~64'd1; end
      default: tk = 1'b0;
    endcase
    return tk ? tgt : fall;
  endfunction

  // Resolve last cycle's packets with this cycle's head/flush, queue the
  // outputs expected next cycle, then capture this cycle's issues.
  task automatic model_cycle();
    exp_t        e;
    int          age[NL];
    logic [63:0] n[NL];
    int          kage, best, bage;
    logic        clr, killed;
    e = '0;
    clr = reset | flush_i;
    best = -1;
    bage = 0;
    if (!clr) begin
      kage = ageOf(mKillCti, ctiHead_i);
      for (int i = 0; i < NL; i++) begin
        n[i]   = pv[i] ? refNpc(pty[i], ppc[i], pimm[i], ps1[i], ps2[i]) : 64'd0;
        age[i] = ageOf(pcti[i], ctiHead_i);
      end
      for (int i = 0; i < NL; i++)
        if (pv[i] && n[i] != ppred[i] && !(mKillV && age[i] > kage) && (best < 0 || age[i] < bage)) begin
          best = i;
          bage = age[i];
        end
      for (int i = 0; i < NL; i++) begin
        killed = (mKillV && age[i] > kage) || (best >= 0 && age[i] > bage);
        if (pv[i] && !killed) begin
          e.cv[i]  = 1'b1;
          e.al[i]  = pal[i];
          e.mp[i]  = (n[i] != ppred[i]);
          e.npc[i] = n[i];
          if (pdv[i]) begin
            e.bv[i]   = 1'b1;
            e.tag[i]  = ptag[i];
            e.data[i] = ppc[i] + 64'd4;
          end
        end
      end
      if (best >= 0) begin
        e.rv = 1'b1;
        e.rpc = n[best];
        e.rcti = pcti[best];
        mKillV = 1'b1;
        mKillCti = pcti[best];
      end
    end else begin
      mKillV = 1'b0;
      mKillCti = '0;
    end
    e.cyc = cyc + 32'd1;
    q.push_back(e);
    for (int i = 0; i < NL; i++) begin
      pv[i]    = !clr && issueValid_i[i] && laneActive_i[i];
      ppc[i]   = pc_i[i];
      ppred[i] = predNPC_i[i];
      pimm[i]  = imm_i[i];
      ps1[i]   = src1Data_i[i];
      ps2[i]   = src2Data_i[i];
      pty[i]   = brType_i[i];
      pcti[i]  = ctiId_i[i];
      pal[i]   = alId_i[i];
      ptag[i]  = phyDest_i[i];
      pdv[i]   = destValid_i[i];
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc == cyc) begin
      me = q.pop_front();
      for (int i = 0; i < NL; i++) begin
        chk("ctrlValid", i, 64'(ctrlValid_o[i]), 64'(me.cv[i]));
        chk("ctrlAlId", i, 64'(ctrlAlId_o[i]), 64'(me.al[i]));
        chk("ctrlMispred", i, 64'(ctrlMispred_o[i]), 64'(me.mp[i]));
        chk("ctrlNPC", i, ctrlNPC_o[i], me.npc[i]);
        chk("bypassValid", i, 64'(bypassValid_o[i]), 64'(me.bv[i]));
        chk("bypassTag", i, 64'(bypassTag_o[i]), 64'(me.tag[i]));
        chk("bypassData", i, bypassData_o[i], me.data[i]);
      end
      chk("redirectValid", 0, 64'(redirectValid_o), 64'(me.rv));
      chk("redirectPC", 0, redirectPC_o, me.rpc);
      chk("redirectCtiId", 0, 64'(redirectCtiId_o), 64'(me.rcti));
      if (me.rv) nRedir++;
    end
  end

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    reset = 1'b0;
    flush_i = 1'b0;
    for (int i = 0; i < NL; i++) issueValid_i[i] = 1'b0;
  endtask

  task automatic set_issue(int ln, logic [3:0] ty, logic [63:0] pc, logic [63:0] pred,
                           logic [63:0] imm, logic [63:0] s1, logic [63:0] s2,
                           logic [CL-1:0] cti, logic [AL-1:0] al, logic [PL-1:0] tag, logic dv);
    issueValid_i[ln] = 1'b1;
    brType_i[ln]     = ty;
    pc_i[ln]         = pc;
    predNPC_i[ln]    = pred;
    imm_i[ln]        = imm;
    src1Data_i[ln]   = s1;
    src2Data_i[ln]   = s2;
    ctiId_i[ln]      = cti;
    alId_i[ln]       = al;
    phyDest_i[ln]    = tag;
    destValid_i[ln]  = dv;
  endtask

  task automatic idle(int n);
    repeat (n) begin begin_cycle(); model_cycle(); end
  endtask

  task automatic flush_cycle();
    begin_cycle(); flush_i = 1'b1; model_cycle();
  endtask

  function automatic logic [63:0] pickOp();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return 64'd5;
      4: return 64'h8000_0000_0000_0000;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic rand_issue(int ln);
    logic [3:0]  ty;
    logic [63:0] pc, imm, s1, s2, pred;
    int          r;
    ty = 4'($urandom_range(0, 7));
    pc = ($urandom_range(0, 19) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : ({$urandom(), $urandom()} & ~64'h3);
    r = int'($urandom_range(0, 4095)) - 2048;
    imm = 64'(r);
    s1 = pickOp();
    s2 = pickOp();
    case ($urandom_range(0, 2))
      0: pred = refNpc(ty, pc, imm, s1, s2);
      1: pred = pc + 64'd4;
      default: pred = pc + imm;
    endcase
    set_issue(ln, ty, pc, pred, imm, s1, s2,
              ($urandom_range(0, 9) == 0) ? CL'($urandom()) : ctiHead_i + CL'($urandom_range(0, 7)),
              AL'($urandom()), PL'($urandom()), 1'($urandom()));
  endtask

  initial begin
    for (int i = 0; i < NL; i++) begin
      issueValid_i[i] = 1'b0; pc_i[i] = '0; predNPC_i[i] = '0; brType_i[i] = '0;
      imm_i[i] = '0; ctiId_i[i] = '0; alId_i[i] = '0; phyDest_i[i] = '0;
      destValid_i[i] = 1'b0; src1Data_i[i] = '0; src2Data_i[i] = '0;
      pv[i] = 1'b0;
    end
    repeat (3) begin begin_cycle(); reset = 1'b1; model_cycle(); end
    idle(2);

    // BEQ taken against a fall-through prediction.
    begin_cycle(); set_issue(0, BR_BEQ, 64'h100, 64'h104, 64'h40, 64'd5, 64'd5, 5'd0, 8'd1, 7'd3, 1'b1); model_cycle();
    idle(2); flush_cycle(); idle(1);
    // JALR link bypass, correctly predicted.
    begin_cycle(); set_issue(1, BR_JALR, 64'h300, 64'h2010, 64'h10, 64'h2001, 64'd0, 5'd1, 8'd2, 7'd9, 1'b1); model_cycle();
    idle(2);
    // Wrapped ages: cti 31 (age 1) beats cti 2 (age 4).
    begin_cycle(); ctiHead_i = 5'd30;
    set_issue(0, BR_JAL, 64'h400, 64'h404, 64'h80, 64'd0, 64'd0, 5'd2, 8'd3, 7'd4, 1'b1);
    set_issue(1, BR_JAL, 64'h500, 64'h504, 64'h90, 64'd0, 64'd0, 5'd31, 8'd4, 7'd5, 1'b1);
    model_cycle();
    idle(2); flush_cycle(); idle(1);
    // Sticky kill: cti 3 redirects, younger cti 5 dies, older cti 1 overrides.
    begin_cycle(); ctiHead_i = 5'd0;
    set_issue(0, BR_JAL, 64'h600, 64'h604, 64'h20, 64'd0, 64'd0, 5'd3, 8'd5, 7'd6, 1'b1); model_cycle();
    begin_cycle(); set_issue(0, BR_JAL, 64'h700, 64'h704, 64'h20, 64'd0, 64'd0, 5'd5, 8'd6, 7'd7, 1'b1); model_cycle();
    begin_cycle(); set_issue(1, BR_JAL, 64'h800, 64'h804, 64'h20, 64'd0, 64'd0, 5'd1, 8'd7, 7'd8, 1'b1); model_cycle();
    idle(3); flush_cycle(); idle(1);
    // Issue during flush is dropped.
    begin_cycle(); flush_i = 1'b1;
    set_issue(0, BR_JAL, 64'h900, 64'h904, 64'h20, 64'd0, 64'd0, 5'd2, 8'd8, 7'd9, 1'b1); model_cycle();
    idle(3);
    // Unsigned vs signed compare of -1 and 1.
    begin_cycle();
    set_issue(0, BR_BLTU, 64'hA00, 64'hA04, 64'h40, '1, 64'd1, 5'd4, 8'd9, 7'd10, 1'b0);
    set_issue(1, BR_BLT, 64'hB00, 64'hB40, 64'h40, '1, 64'd1, 5'd5, 8'd10, 7'd11, 1'b1);
    model_cycle();
    idle(2);
    // Inactive lane drops its issue; reset mid-flight clears everything.
    begin_cycle(); laneActive_i = 2'b01;
    set_issue(1, BR_JAL, 64'hC00, 64'hC04, 64'h20, 64'd0, 64'd0, 5'd6, 8'd11, 7'd12, 1'b1);
    set_issue(0, BR_BNE, 64'hD00, 64'hD04, 64'h20, 64'd1, 64'd2, 5'd7, 8'd12, 7'd13, 1'b1); model_cycle();
    begin_cycle(); laneActive_i = 2'b11;
    set_issue(0, BR_JAL, 64'hE00, 64'hE04, 64'h20, 64'd0, 64'd0, 5'd8, 8'd13, 7'd14, 1'b1); model_cycle();
    begin_cycle(); reset = 1'b1; model_cycle();
    idle(3);

    for (int c = 0; c < 3000; c++) begin
      begin_cycle();
      if ($urandom_range(0, 99) < 7) flush_i = 1'b1;
      if ($urandom_range(0, 299) == 0) reset = 1'b1;
      if ($urandom_range(0, 9) == 0) ctiHead_i = ctiHead_i + 5'd1;
      if ($urandom_range(0, 29) == 0) laneActive_i = NL'($urandom());
      if ($urandom_range(0, 29) == 0) laneActive_i = '1;
      for (int i = 0; i < NL; i++)
        if ($urandom_range(0, 99) < 70) rand_issue(i);
      model_cycle();
    end
    idle(3);
    repeat (3) @(negedge clk);
    chk("scoreboardDrained", 0, 64'(q.size()), 64'd0);
    if (nRedir == 0) chk("redirectSeen", 0, 64'(nRedir), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

endmodule
